dpram_march_bist: RTL

Built-in self-test engine that drives a `dpram_r1w1` dual-port RAM from the initiator side. It runs a March C- test, writing through port A and reading through port B, and compares every read against the expected word. It reports pass/fail plus the first failing address and data. It sits between a test controller (MyHDL co-sim bench or a top-level status register) and the RAM instance.

---
 rtl/dpram_bist_pkg.sv | 49 ++++
 rtl/dpram_march_bist_if.sv | 42 ++++
 rtl/dpram_bist_addrgen.sv | 53 +++++
 rtl/dpram_march_bist.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/dpram_bist_pkg.sv
// ============================================================================
// dpram_bist_pkg : state encoding, March C- element table and pattern helper
// Revision 1.0
// ============================================================================
`default_nettype none

package dpram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_M0   = 3'd1,
    ST_M1   = 3'd2,
    ST_M2   = 3'd3,
    ST_M3   = 3'd4,
    ST_M4   = 3'd5,
    ST_M5   = 3'd6,
    ST_DONE = 3'd7
  } state_e;

  typedef struct packed {
    logic dn;       // sweep N-1 down to 0
    logic has_rd;   // element starts with a read
    logic exp_pol;  // polarity expected on that read
    logic has_wr;   // element writes
    logic wr_pol;   // polarity written
  } elem_t;

  // Indexed directly by state_e; IDLE and DONE rows are inert.
  localparam elem_t ELEM_TBL [8] = '{
    '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0},  // IDLE
    '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0},  // M0 up   w0
    '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1},  // M1 up   r0 w1
    '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0},  // M2 up   r1 w0
    '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1},  // M3 down r0 w1
    '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},  // M4 down r1 w0
    '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0},  // M5 down r0
    '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0}   // DONE
  };

  localparam int MAX_DATA_W = 64;

  function automatic logic [MAX_DATA_W-1:0] pattern(input logic pol,
                                                    input logic [MAX_DATA_W-1:0] bg);
    return pol ? ~bg : bg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dpram_march_bist_if.sv
// ============================================================================
// dpram_march_bist_if : controller status and RAM port signals of the BIST
// Revision 1.0
// ============================================================================
`default_nettype none

interface dpram_march_bist_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);

  logic              start;
  logic              busy;
  logic              done;
  logic              fail;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_data;
  logic              a_ce;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_write;
  logic              b_ce;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_write;
  logic [DATA_W-1:0] b_read;

  modport master (
    input  start, b_read,
    output busy, done, fail, fail_addr, fail_data,
           a_ce, a_we, a_addr, a_write, b_ce, b_we, b_addr, b_write
  );

  modport slave (
    output start, b_read,
    input  busy, done, fail, fail_addr, fail_data,
           a_ce, a_we, a_addr, a_write, b_ce, b_we, b_addr, b_write
  );

endinterface

`default_nettype wire

// File: rtl/dpram_bist_addrgen.sv
// ============================================================================
// dpram_bist_addrgen : loadable up/down address counter with terminal flag and
//                      a one-cycle-delayed copy used by the write/compare stage
// Revision 1.0
// ============================================================================
`default_nettype none

module dpram_bist_addrgen #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              ld_dn_i,
  input  logic              step_i,
  input  logic              dn_i,
  input  logic              same_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [ADDR_W-1:0] dly_o,
  output logic              tc_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] dly_q, dly_d;

  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = ld_dn_i ? '1 : '0;
    end else if (step_i) begin
      addr_d = dn_i ? (addr_q - 1'b1) : (addr_q + 1'b1);
    end
    // Write-only elements write the address being issued, not the previous one.
    dly_d = same_i ? addr_d : addr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      dly_q  <= '0;
    end else begin
      addr_q <= addr_d;
      dly_q  <= dly_d;
    end
  end

  assign addr_o = addr_q;
  assign dly_o  = dly_q;
  assign tc_o   = dn_i ? (addr_q == '0) : (addr_q == '1);

endmodule

`default_nettype wire

// File: rtl/dpram_march_bist.sv
// ============================================================================
// dpram_march_bist : March C- engine, writes via port A, reads/compares via B
// Revision 1.0
// ============================================================================
`default_nettype none

module dpram_march_bist
  import dpram_bist_pkg::*;
#(
  parameter int                ADDR_W = 12,
  parameter int                DATA_W = 16,
  parameter logic [DATA_W-1:0] BG     = DATA_W'(16'h5A5A)
) (
  input logic                clk,
  input logic                reset,
  dpram_march_bist_if.master bus
);

  state_e            state_q, state_d;
  logic              rd_q, rd_d;      // this cycle issues the element's read (or M0 write)
  logic              pend_q, pend_d;  // previous cycle read: compare and write back now
  logic              load, step, accept, mismatch;
  logic              a_ce_q, a_ce_d, b_ce_q, b_ce_d;
  logic [DATA_W-1:0] a_write_q, a_write_d, exp_w;
  logic              busy_q, done_q, fail_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [DATA_W-1:0] fail_data_q;
  logic [ADDR_W-1:0] addr, dly;
  logic              tc;

  function automatic logic [DATA_W-1:0] pat(input logic pol);
    return DATA_W'(pattern(pol, MAX_DATA_W'(BG)));
  endfunction

  dpram_bist_addrgen #(.ADDR_W(ADDR_W)) u_addrgen (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .ld_dn_i (ELEM_TBL[state_d].dn),
    .step_i  (step),
    .dn_i    (ELEM_TBL[state_q].dn),
    .same_i  (state_d == ST_M0),
    .addr_o  (addr),
    .dly_o   (dly),
    .tc_o    (tc)
  );

  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    pend_d    = pend_q;
    load      = 1'b0;
    step      = 1'b0;
    accept    = 1'b0;
    exp_w     = pat(ELEM_TBL[state_q].exp_pol);
    mismatch  = ELEM_TBL[state_q].has_rd && pend_q && (bus.b_read != exp_w);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = ST_M0;
          load    = 1'b1;
          rd_d    = 1'b1;
          pend_d  = 1'b0;
        end
      end
      default: begin
        if (mismatch) begin
          state_d = ST_DONE;
          rd_d    = 1'b0;
          pend_d  = 1'b0;
        end else if (ELEM_TBL[state_q].has_rd ? !rd_q : tc) begin
          // Element complete; M5 + 1 encodes DONE.
          state_d = state_e'(state_q + 3'd1);
          pend_d  = 1'b0;
          rd_d    = (state_d != ST_DONE);
          load    = (state_d != ST_DONE);
        end else begin
          step = 1'b1;
          if (ELEM_TBL[state_q].has_rd) begin
            pend_d = 1'b1;
            rd_d   = !tc;
          end
        end
      end
    endcase

    a_ce_d    = ELEM_TBL[state_d].has_wr &&
                (ELEM_TBL[state_d].has_rd ? pend_d : rd_d);
    b_ce_d    = ELEM_TBL[state_d].has_rd && rd_d;
    a_write_d = a_ce_d ? pat(ELEM_TBL[state_d].wr_pol) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rd_q        <= 1'b0;
      pend_q      <= 1'b0;
      a_ce_q      <= 1'b0;
      b_ce_q      <= 1'b0;
      a_write_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      pend_q    <= pend_d;
      a_ce_q    <= a_ce_d;
      b_ce_q    <= b_ce_d;
      a_write_q <= a_write_d;
      busy_q    <= (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_q    <= (state_d == ST_DONE);
      if (accept) begin
        fail_q      <= 1'b0;
        fail_addr_q <= '0;
        fail_data_q <= '0;
      end else if (mismatch && !fail_q) begin
        fail_q      <= 1'b1;
        fail_addr_q <= dly;
        fail_data_q <= bus.b_read;
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fail      = fail_q;
  assign bus.fail_addr = fail_addr_q;
  assign bus.fail_data = fail_data_q;
  assign bus.a_ce      = a_ce_q;
  assign bus.a_we      = a_ce_q;
  assign bus.a_addr    = dly;
  assign bus.a_write   = a_write_q;
  assign bus.b_ce      = b_ce_q;
  assign bus.b_we      = 1'b0;
  assign bus.b_addr    = addr;
  assign bus.b_write   = '0;

endmodule

`default_nettype wire
